seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Holds a 16-bit hex value and walks digits 0..3.
- Per digit: presents the digit's nibble to the downstream hex-to-7-segment decoder and drives the active-low anode and decimal-point lines.
- A blanking gap between digits prevents ghosting. New values are committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- SHOW_CYCLES, 50000: clocks each digit's anode is on; must be >= 2.
- BLANK_CYCLES, 16: clocks all anodes are off before each digit; must be >= 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- value, input, 16: digit i = value[4i+3:4i]; digit 0 is rightmost.
- load, input, 1: capture value/blank_mask/dp_in/lzs into the pending registers.
- blank_mask, input, 4: bit i = 1 forces digit i dark.
- dp_in, input, 4: bit i = 1 lights the decimal point of digit i.
- lzs, input, 1: leading-zero suppression enable.
- nibble, output, 4: current digit's hex code, to the segment decoder.
- an, output, 4: anode enables, active-low, one-hot-low or all ones.
- dp, output, 1: decimal point, active-low.
- digit_idx, output, 2: digit currently addressed.
- frame_done, output, 1: one-cycle pulse at each frame wrap.

Behaviour:
- Registers:
  - pending set P: value, mask, dp, lzs.
  - active set A: same fields.
  - state: BLANK or SHOW.
  - idx[1:0], cnt.
- Reset (async, rst_n low, effective immediately, also mid-frame):
  - P = A = 0; state = BLANK; idx = 0; cnt = 0.
  - Outputs: an = 4'b1111, dp = 1, nibble = 0, digit_idx = 0, frame_done = 0.
- load:
  - load = 1 at an edge writes P.
  - Repeated loads within a frame overwrite P; last one wins.
  - load does not touch A.
- BLANK:
  - an = 4'b1111, dp = 1.
  - cnt counts 0..BLANK_CYCLES-1; at BLANK_CYCLES-1: state <= SHOW, cnt <= 0.
- SHOW:
  - cnt counts 0..SHOW_CYCLES-1; at SHOW_CYCLES-1: state <= BLANK, cnt <= 0, idx <= idx+1 (wraps 3 -> 0).
- Frame wrap (SHOW, idx = 3, cnt = SHOW_CYCLES-1):
  - Same edge: A <= P, and frame_done = 1 for the following single cycle.
  - A load on that same edge goes to P only; it takes effect at the next wrap.
- Outputs are pure decodes of registers; there is no combinational path from inputs to outputs.
  - nibble = A.value[4*idx+:4] in both states, so it is stable before the anode turns on.
  - digit_idx = idx.
- Suppression:
  - digit i (i = 1..3) is suppressed when A.lzs = 1 and A.value digits i..3 are all zero.
  - Digit 0 is never suppressed.
- Digit enable: en(i) = !A.mask[i] && !suppressed(i).
- In SHOW:
  - an[idx] = !en(idx); all other an bits = 1.
  - dp = !(en(idx) && A.dp[idx]).
- Timing:
  - Frame length = 4*(BLANK_CYCLES+SHOW_CYCLES) clocks.
  - First anode low occurs BLANK_CYCLES edges after reset release.
- Changes to blank_mask, dp_in or lzs take effect only via load plus frame wrap.

Test Plan:
(Parameters for all scenarios: SHOW_CYCLES = 4, BLANK_CYCLES = 2; frame = 24 clocks.)
- Reset, then load value = 16'h1234, blank_mask = 0, lzs = 0:
  - First frame shows 0000 (A not yet committed).
  - After the first frame_done: nibble 4,3,2,1 with an 1110,1101,1011,0111, each low for exactly 4 clocks, separated by 2 clocks of an = 1111.
- Load value = 16'h0050 with lzs = 1:
  - After commit, digits 3 and 2 keep an = 1111 during their SHOW.
  - Digits 1 and 0 light with nibble 5 and 0.
  - value = 16'h0000 with lzs = 1 lights only digit 0.
- blank_mask = 4'b0100, dp_in = 4'b0101:
  - Digit 2 stays dark and its dp stays 1.
  - dp = 0 only during digit 0's SHOW.
- Three loads (16'hAAAA, 16'hBBBB, 16'hCCCC) mid-frame:
  - Next frame shows C on all digits.
  - A load on the wrap edge itself appears one frame later.
- Assert rst_n low mid-SHOW of digit 2:
  - an = 1111, digit_idx = 0, dp = 1 immediately, without waiting for a clock edge.
  - After release, the scan restarts in BLANK at digit 0 displaying 0.
- Count frame_done over 3 frames:
  - Exactly 3 single-cycle pulses, 24 clocks apart.
  - Each pulse coincides with digit_idx = 0 in BLANK.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
// Bus between a host and the 4-digit 7-segment scan controller.
//   value      : 16-bit hex value, digit i = value[4i+3:4i], digit 0 rightmost
//   load       : capture value/blank_mask/dp_in/lzs into the pending set
//   blank_mask : bit i forces digit i dark
//   dp_in      : bit i lights the decimal point of digit i
//   lzs        : leading-zero suppression enable
//   nibble     : hex code of the addressed digit, to the segment decoder
//   an         : active-low anode enables (one-hot-low or all ones)
//   dp         : active-low decimal point
//   digit_idx  : digit currently addressed
//   frame_done : one-cycle pulse after each frame wrap
// The master modport is the host side; the slave modport is the controller.
interface seg_scan_ctrl_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic        lzs;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  modport master (
    output value, load, blank_mask, dp_in, lzs,
    input  nibble, an, dp, digit_idx, frame_done
  );

  modport slave (
    input  value, load, blank_mask, dp_in, lzs,
    output nibble, an, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each digit gets BLANK_CYCLES clocks with all anodes off followed
// by SHOW_CYCLES clocks with its anode on. Host writes land in a pending
// register set; the displayed (active) set is refreshed from it only at the
// frame wrap, so one frame never mixes old and new digits.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_ctrl_if.slave (value/load/blank_mask/dp_in/lzs in,
//           nibble/an/dp/digit_idx/frame_done out)
module seg_scan_ctrl #(
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // pending set (host-written) and active set (displayed)
  logic [15:0] p_value;
  logic [3:0]  p_mask;
  logic [3:0]  p_dp;
  logic        p_lzs;
  logic [15:0] a_value;
  logic [3:0]  a_mask;
  logic [3:0]  a_dp;
  logic        a_lzs;

  logic [0:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic          frame_done_r;

  logic [3:0] suppressed;
  logic [3:0] en;
  logic       cur_en;
  logic [3:0] an_d;
  logic       dp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_value      <= '0;
      p_mask       <= '0;
      p_dp         <= '0;
      p_lzs        <= 1'b0;
      a_value      <= '0;
      a_mask       <= '0;
      a_dp         <= '0;
      a_lzs        <= 1'b0;
      state        <= ST_BLANK;
      idx          <= '0;
      cnt          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.load) begin
        p_value <= bus.value;
        p_mask  <= bus.blank_mask;
        p_dp    <= bus.dp_in;
        p_lzs   <= bus.lzs;
      end

      frame_done_r <= 1'b0;

      if (state == ST_BLANK) begin
        if (cnt == BLANK_LAST) begin
          state <= ST_SHOW;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == SHOW_LAST) begin
          state <= ST_BLANK;
          cnt   <= '0;
          idx   <= idx + 2'd1;
          // Frame wrap: the active set takes the pending set as it stood
          // before this edge, so a load on the wrap edge waits one frame.
          if (idx == 2'd3) begin
            a_value      <= p_value;
            a_mask       <= p_mask;
            a_dp         <= p_dp;
            a_lzs        <= p_lzs;
            frame_done_r <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // A digit is suppressed when it and every digit to its left are zero;
  // digit 0 always shows so a zero value still reads "0".
  assign suppressed[0] = 1'b0;
  assign suppressed[1] = a_lzs && (a_value[15:4]  == 12'h000);
  assign suppressed[2] = a_lzs && (a_value[15:8]  == 8'h00);
  assign suppressed[3] = a_lzs && (a_value[15:12] == 4'h0);

  assign en     = ~a_mask & ~suppressed;
  assign cur_en = en[idx];

  always_comb begin
    an_d = 4'b1111;
    dp_d = 1'b1;
    if (state == ST_SHOW) begin
      an_d[idx] = ~cur_en;
      dp_d      = ~(cur_en & a_dp[idx]);
    end
  end

  // nibble is decoded in BLANK too, so the segments settle before the anode turns on
  assign bus.nibble     = a_value[{idx, 2'b00} +: 4];
  assign bus.an         = an_d;
  assign bus.dp         = dp_d;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Directed self-checking bench for seg_scan_ctrl with SHOW_CYCLES = 4 and
// BLANK_CYCLES = 2 (24-clock frame). Position counter pos counts rising
// edges since reset release; frame offset o = pos % 24 maps to digit o/6,
// with offsets 0..1 of each digit in BLANK and 2..5 in SHOW.
module tb_seg_scan_ctrl;

  localparam int FRAME = 24;

  logic clk;
  logic rst_n;
  int   pos;
  int   total;
  int   passed;

  logic [3:0] cap_an  [FRAME];
  logic [3:0] cap_nib [FRAME];
  logic       cap_dp  [FRAME];
  logic       cap_fd  [FRAME];
  logic [1:0] cap_idx [FRAME];

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .SHOW_CYCLES (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected anode pattern at frame offset o, given the SHOW pattern of each digit
  function automatic logic [3:0] exp_an(int o, logic [15:0] show);
    int d;
    d = o / 6;
    if ((o % 6) < 2) return 4'hF;
    return show[4*d +: 4];
  endfunction

  function automatic logic exp_dp(int o, logic [3:0] dps);
    if ((o % 6) < 2) return 1'b1;
    return dps[o / 6];
  endfunction

  function automatic logic [3:0] exp_nib(int o, logic [15:0] v);
    return v[4*(o / 6) +: 4];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m,
                         input logic [3:0] d, input logic l);
    bus.value      = v;
    bus.blank_mask = m;
    bus.dp_in      = d;
    bus.lzs        = l;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  task automatic run_to_frame_start;
    while ((pos % FRAME) != 0) tick();
  endtask

  // records outputs at each offset from the current one up to the next wrap
  task automatic capture_to_wrap;
    do begin
      cap_an [pos % FRAME] = bus.an;
      cap_nib[pos % FRAME] = bus.nibble;
      cap_dp [pos % FRAME] = bus.dp;
      cap_fd [pos % FRAME] = bus.frame_done;
      cap_idx[pos % FRAME] = bus.digit_idx;
      tick();
    end while ((pos % FRAME) != 0);
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.value      = '0;
    bus.load       = 1'b0;
    bus.blank_mask = '0;
    bus.dp_in      = '0;
    bus.lzs        = 1'b0;
    #3;
    total += 5;
    if (bus.an !== 4'b1111) $display("[TB] FAIL reset_an got %b want 1111", bus.an); else passed++;
    if (bus.dp !== 1'b1) $display("[TB] FAIL reset_dp got %b want 1", bus.dp); else passed++;
    if (bus.nibble !== 4'h0) $display("[TB] FAIL reset_nibble got %h want 0", bus.nibble); else passed++;
    if (bus.digit_idx !== 2'd0) $display("[TB] FAIL reset_idx got %0d want 0", bus.digit_idx); else passed++;
    if (bus.frame_done !== 1'b0) $display("[TB] FAIL reset_fd got %b want 0", bus.frame_done); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = 0;
  endtask

  task automatic test_first_frame;
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    capture_to_wrap();
    for (int o = 1; o < FRAME; o++) begin
      total += 4;
      if (cap_an[o] !== exp_an(o, 16'h7BDE)) $display("[TB] FAIL first_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'h7BDE)); else passed++;
      if (cap_nib[o] !== 4'h0) $display("[TB] FAIL first_nibble off=%0d got %h want 0", o, cap_nib[o]); else passed++;
      if (cap_dp[o] !== 1'b1) $display("[TB] FAIL first_dp off=%0d got %b want 1", o, cap_dp[o]); else passed++;
      if (cap_fd[o] !== 1'b0) $display("[TB] FAIL first_fd off=%0d got %b want 0", o, cap_fd[o]); else passed++;
    end
  endtask

  task automatic test_value_scan;
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 5;
      if (cap_an[o] !== exp_an(o, 16'h7BDE)) $display("[TB] FAIL scan_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'h7BDE)); else passed++;
      if (cap_nib[o] !== exp_nib(o, 16'h1234)) $display("[TB] FAIL scan_nibble off=%0d got %h want %h", o, cap_nib[o], exp_nib(o, 16'h1234)); else passed++;
      if (cap_dp[o] !== 1'b1) $display("[TB] FAIL scan_dp off=%0d got %b want 1", o, cap_dp[o]); else passed++;
      if (cap_fd[o] !== (o == 0)) $display("[TB] FAIL scan_fd off=%0d got %b want %b", o, cap_fd[o], (o == 0)); else passed++;
      if (cap_idx[o] !== 2'(o / 6)) $display("[TB] FAIL scan_idx off=%0d got %0d want %0d", o, cap_idx[o], o / 6); else passed++;
    end
  endtask

  task automatic test_lzs;
    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    run_to_frame_start();
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 3;
      if (cap_an[o] !== exp_an(o, 16'hFFDE)) $display("[TB] FAIL lzs_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'hFFDE)); else passed++;
      if (cap_nib[o] !== exp_nib(o, 16'h0050)) $display("[TB] FAIL lzs_nibble off=%0d got %h want %h", o, cap_nib[o], exp_nib(o, 16'h0050)); else passed++;
      if (cap_dp[o] !== 1'b1) $display("[TB] FAIL lzs_dp off=%0d got %b want 1", o, cap_dp[o]); else passed++;
    end
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run_to_frame_start();
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 2;
      if (cap_an[o] !== exp_an(o, 16'hFFFE)) $display("[TB] FAIL lzs0_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'hFFFE)); else passed++;
      if (cap_nib[o] !== 4'h0) $display("[TB] FAIL lzs0_nibble off=%0d got %h want 0", o, cap_nib[o]); else passed++;
    end
  endtask

  task automatic test_mask_dp;
    do_load(16'h1234, 4'b0100, 4'b0101, 1'b0);
    run_to_frame_start();
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 3;
      if (cap_an[o] !== exp_an(o, 16'h7FDE)) $display("[TB] FAIL mask_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'h7FDE)); else passed++;
      if (cap_dp[o] !== exp_dp(o, 4'b1110)) $display("[TB] FAIL mask_dp off=%0d got %b want %b", o, cap_dp[o], exp_dp(o, 4'b1110)); else passed++;
      if (cap_nib[o] !== exp_nib(o, 16'h1234)) $display("[TB] FAIL mask_nibble off=%0d got %h want %h", o, cap_nib[o], exp_nib(o, 16'h1234)); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    repeat (3) tick();
    do_load(16'hAAAA, 4'b0000, 4'b0000, 1'b0);
    tick();
    do_load(16'hBBBB, 4'b0000, 4'b0000, 1'b0);
    tick();
    do_load(16'hCCCC, 4'b0000, 4'b0000, 1'b0);
    while ((pos % FRAME) != FRAME - 1) tick();
    // this load lands on the wrap edge itself
    do_load(16'hDDDD, 4'b0000, 4'b0000, 1'b0);
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 2;
      if (cap_nib[o] !== 4'hC) $display("[TB] FAIL b2b_nibble off=%0d got %h want c", o, cap_nib[o]); else passed++;
      if (cap_an[o] !== exp_an(o, 16'h7BDE)) $display("[TB] FAIL b2b_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'h7BDE)); else passed++;
    end
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 1;
      if (cap_nib[o] !== 4'hD) $display("[TB] FAIL wrapload_nibble off=%0d got %h want d", o, cap_nib[o]); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    run_to_frame_start();
    repeat (15) tick();
    total += 2;
    if (bus.digit_idx !== 2'd2) $display("[TB] FAIL pre_rst_idx got %0d want 2", bus.digit_idx); else passed++;
    if (bus.an !== 4'b1011) $display("[TB] FAIL pre_rst_an got %b want 1011", bus.an); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.an !== 4'b1111) $display("[TB] FAIL mid_rst_an got %b want 1111", bus.an); else passed++;
    if (bus.digit_idx !== 2'd0) $display("[TB] FAIL mid_rst_idx got %0d want 0", bus.digit_idx); else passed++;
    if (bus.dp !== 1'b1) $display("[TB] FAIL mid_rst_dp got %b want 1", bus.dp); else passed++;
    if (bus.nibble !== 4'h0) $display("[TB] FAIL mid_rst_nibble got %h want 0", bus.nibble); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = 0;
    capture_to_wrap();
    for (int o = 0; o < FRAME; o++) begin
      total += 4;
      if (cap_an[o] !== exp_an(o, 16'h7BDE)) $display("[TB] FAIL restart_an off=%0d got %b want %b", o, cap_an[o], exp_an(o, 16'h7BDE)); else passed++;
      if (cap_nib[o] !== 4'h0) $display("[TB] FAIL restart_nibble off=%0d got %h want 0", o, cap_nib[o]); else passed++;
      if (cap_idx[o] !== 2'(o / 6)) $display("[TB] FAIL restart_idx off=%0d got %0d want %0d", o, cap_idx[o], o / 6); else passed++;
      if (cap_fd[o] !== 1'b0) $display("[TB] FAIL restart_fd off=%0d got %b want 0", o, cap_fd[o]); else passed++;
    end
  endtask

  task automatic test_frame_done;
    int pulses;
    int last;
    pulses = 0;
    last   = pos;
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      if (bus.frame_done === 1'b1) begin
        pulses++;
        total += 3;
        if ((pos - last) !== FRAME) $display("[TB] FAIL fd_spacing got %0d want %0d", pos - last, FRAME); else passed++;
        if (bus.digit_idx !== 2'd0) $display("[TB] FAIL fd_idx got %0d want 0", bus.digit_idx); else passed++;
        if (bus.an !== 4'b1111) $display("[TB] FAIL fd_an got %b want 1111", bus.an); else passed++;
        last = pos;
      end
    end
    total += 1;
    if (pulses !== 3) $display("[TB] FAIL fd_count got %0d want 3", pulses); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    pos    = 0;
    test_reset();
    test_first_frame();
    test_value_scan();
    test_lzs();
    test_mask_dp();
    test_back_to_back();
    test_reset_mid();
    test_frame_done();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
